i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S slave receiver for the codec ADC path (codec DOUT into the FPGA). It is the capture-side counterpart of the existing i2s transmitter.
- Oversamples externally driven sck/lr/d in the 56 MHz system clock domain and deserialises left and right words.
- Presents each completed stereo frame with a one-cycle strobe.
- Derives a digital tape EAR bit from the left channel, so line-in tape loading runs through the codec instead of the dedicated ear pin.

Parameters:
- DW, 16: captured word width per channel, MSB first.
- MAXB, 32: maximum sck rising edges allowed per half-frame before overrun.
- ETH, 512: signed EAR threshold applied to ldata.
- HYST, 256: EAR hysteresis half-width; used only with the optional feature.

Ports:
- clock  in  1  system clock, 56 MHz.
- reset  in  1  synchronous, active-high.
- sck  in  1  I2S bit clock from the codec, asynchronous, ≤3.5 MHz.
- lr  in  1  I2S word select; 0 = left, 1 = right; asynchronous.
- d  in  1  I2S serial data, asynchronous.
- ldata  out  DW  left sample, two's complement.
- rdata  out  DW  right sample, two's complement.
- strobe  out  1  one-cycle pulse: ldata/rdata updated.
- locked  out  1  frame alignment good.
- ear  out  1  tape EAR level derived from ldata.

Behaviour:
- Synchronisation: sck, lr and d each pass through identical 2-FF synchronisers plus one history FF. This preserves their relative timing. Edges are detected on the synchronised copies.
- Raw-to-strobe latency: exactly 3 clock cycles from the clock edge where the first sync FF captures an lr high-to-low change to strobe high.
- Bit counting:
  - The counter resets on every synchronised lr edge.
  - It counts sck rising edges and saturates at MAXB+1.
  - Edge #1 is the I2S delay slot and is ignored.
  - Edges #2..#DW+1 shift d into the channel shift register, MSB first.
  - Later edges are ignored.
- Simultaneous events: if an sck rising edge and an lr edge occur in the same cycle, the lr edge wins. That sck edge counts as edge #1 of the new half-frame.
- States:
  - SYNC: after reset. Wait for an lr falling edge and discard any partial data.
  - LEFT: capturing while lr=0. An lr rising edge commits the left word to a hold register and moves to RIGHT.
  - RIGHT: capturing while lr=1. An lr falling edge commits the right word, loads ldata from the hold register and rdata from the shift register, pulses strobe, and returns to LEFT.
- Short half-frame (count < DW+1 at the lr edge): remaining low bits are zero-filled, left-justified. The word is still committed and the half is marked malformed.
- Overrun (count > MAXB at the lr edge): the word (first DW bits) is committed and the half is marked malformed.
- locked:
  - Set on the strobe that completes the second consecutive frame in which both halves were well-formed.
  - Cleared in the same cycle any malformed half-frame commits.
- strobe fires only for frames whose left half started in LEFT, never for the frame in progress when SYNC exits.
- ear (no feature): updated on the strobe cycle. ear = 1 if signed ldata ≥ ETH, else 0.
- Reset values: ldata = 0, rdata = 0, strobe = 0, locked = 0, ear = 0, state = SYNC, counters = 0.
- Reset asserted mid-frame: the partial frame is discarded, no strobe is produced for it, and the next strobe follows the next complete L+R frame.

Optional Feature:
- Macro: I2S_RX_EAR_HYST_EN.
- Defined: ear is a Schmitt trigger, evaluated on strobe.
  - It sets when signed ldata ≥ ETH+HYST.
  - It clears when signed ldata ≤ ETH−HYST.
  - Otherwise it holds.
- Undefined: single-threshold compare as in Behaviour; HYST is unused.

Test Plan:
1. Assert reset 4 cycles with random sck/lr/d toggling → all outputs 0, no strobe during or 50 cycles after release with lr held high.
2. Stream 32-bit slots (sck period 18 clocks), L=16'h8001, R=16'h7FFE, after reset.
   - The first partial frame produces no strobe.
   - Each following frame gives exactly one strobe with ldata=8001, rdata=7FFE, arriving 3 cycles after raw lr falls.
   - locked rises on the second full frame's strobe.
3. Once locked, send one left half with 10-bit slots, transmitting all ones → ldata=16'hFF80; locked drops in the cycle that left word commits. Restore 32-bit slots → locked returns after 2 good frames.
4. Send 40-bit slots with MAXB=32 → ldata/rdata hold the first 16 data bits; locked stays 0.
5. Left sequence 600, 400, 600 (ETH=512) → ear 1, 0, 1.
   - With I2S_RX_EAR_HYST_EN, left sequence 600, 800, 400, 200 → ear 0, 1, 1, 0.
6. Pulse reset for 1 cycle mid left word while locked → locked=0, no strobe for that frame, and the next strobe carries the next full frame's values.

Source files
------------

// File: rtl/i2s_rx_if.sv
// I2S capture-side bus: serial lines from the codec plus the decoded frame outputs.
interface i2s_rx_if #(
  parameter int DW = 16
);
  logic          sck;
  logic          lr;
  logic          d;
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          strobe;
  logic          locked;
  logic          ear;

  modport master (
    output sck, lr, d,
    input  ldata, rdata, strobe, locked, ear
  );

  modport slave (
    input  sck, lr, d,
    output ldata, rdata, strobe, locked, ear
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sck/lr/d, deserialises L/R words, derives a tape EAR bit.
// Optional Schmitt-trigger EAR enabled by defining I2S_RX_EAR_HYST_EN.
module i2s_rx #(
  parameter int DW   = 16,
  parameter int MAXB = 32,
  parameter int ETH  = 512,
  parameter int HYST = 256
) (
  input  logic     clock,
  input  logic     reset,
  i2s_rx_if.slave  bus
);
  localparam int CW = $clog2(MAXB + 2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAXB + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXB);
  localparam logic [CW-1:0] CNT_FULL = CW'(DW + 1);

`ifdef I2S_RX_EAR_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif
  // Without hysteresis the clear threshold sits just below the set threshold.
  localparam int SET_TH = HYST_EN ? ETH + HYST : ETH;
  localparam int CLR_TH = HYST_EN ? ETH - HYST : ETH - 1;

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  // Bit order in the sync vectors: [2]=sck, [1]=lr, [0]=d.
  logic [2:0] raw;
  logic [2:0] s1_q, s2_q, hist_q;

  assign raw = {bus.sck, bus.lr, bus.d};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hist_q <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  logic sck_rise, lr_rise, lr_fall, lr_edge, d_bit, half_bad;

  assign sck_rise = s2_q[2] & ~hist_q[2];
  assign lr_rise  = s2_q[1] & ~hist_q[1];
  assign lr_fall  = ~s2_q[1] & hist_q[1];
  assign lr_edge  = lr_rise | lr_fall;
  assign d_bit    = hist_q[0];

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] shift_q, hold_q, lw_q, rw_q;
  logic          hold_bad_q, good_q, lock_q, stb_q;

  assign half_bad = (cnt_q < CNT_FULL) || (cnt_q > CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      cnt_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_bad_q <= 1'b0;
      good_q     <= 1'b0;
      lock_q     <= 1'b0;
      stb_q      <= 1'b0;
      lw_q       <= '0;
      rw_q       <= '0;
    end else begin
      stb_q <= 1'b0;
      // An lr edge always wins; a coincident sck rise becomes slot #1 of the new half.
      if (lr_edge) begin
        cnt_q   <= sck_rise ? CW'(1) : '0;
        shift_q <= '0;
      end else if (sck_rise) begin
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CW'(1);
        for (int i = 0; i < DW; i++) begin
          if (cnt_q == CW'(DW - i)) shift_q[i] <= d_bit;
        end
      end

      case (state_q)
        ST_SYNC: begin
          if (lr_fall) state_q <= ST_LEFT;
        end
        ST_LEFT: begin
          if (lr_rise) begin
            hold_q     <= shift_q;
            hold_bad_q <= half_bad;
            if (half_bad) begin
              lock_q <= 1'b0;
              good_q <= 1'b0;
            end
            state_q <= ST_RIGHT;
          end
        end
        ST_RIGHT: begin
          if (lr_fall) begin
            lw_q  <= hold_q;
            rw_q  <= shift_q;
            stb_q <= 1'b1;
            if (hold_bad_q || half_bad) begin
              lock_q <= 1'b0;
              good_q <= 1'b0;
            end else begin
              if (good_q) lock_q <= 1'b1;
              good_q <= 1'b1;
            end
            state_q <= ST_LEFT;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  logic [DW-1:0] ldata_q, rdata_q;
  logic          strobe_q, locked_q, ear_q, ear_d;
  int            lw_int;

  always_comb begin
    lw_int = int'($signed(lw_q));
    ear_d  = ear_q;
    if (lw_int >= SET_TH)      ear_d = 1'b1;
    else if (lw_int <= CLR_TH) ear_d = 1'b0;
  end

  // Output stage: everything the host sees moves together one cycle after the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      ldata_q  <= '0;
      rdata_q  <= '0;
      strobe_q <= 1'b0;
      locked_q <= 1'b0;
      ear_q    <= 1'b0;
    end else begin
      strobe_q <= stb_q;
      locked_q <= lock_q;
      if (stb_q) begin
        ldata_q <= lw_q;
        rdata_q <= rw_q;
        ear_q   <= ear_d;
      end
    end
  end

  assign bus.ldata  = ldata_q;
  assign bus.rdata  = rdata_q;
  assign bus.strobe = strobe_q;
  assign bus.locked = locked_q;
  assign bus.ear    = ear_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S streams, predicts each frame's strobe in a scoreboard queue.
module tb_i2s_rx;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2s_rx_if #(.DW(DW)) bus();

  i2s_rx #(.DW(DW), .MAXB(32), .ETH(512), .HYST(256)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
    logic        lk;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int strobes_seen = 0;
  logic        pend_valid = 1'b0;
  logic [15:0] pend_l, pend_r;
  logic        pend_lk, pend_er;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every strobe must match the oldest predicted frame.
  always @(negedge clk) begin
    exp_t e;
    if (bus.strobe === 1'b1) begin
      strobes_seen++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe cyc=%0d ldata=%h rdata=%h required no strobe", cyc, bus.ldata, bus.rdata);
      end else begin
        e = sb.pop_front();
        if ({bus.ldata, bus.rdata} !== {e.l, e.r}) begin
          n_fail++;
          $display("FAIL frame_data ldata=%h rdata=%h required %h %h", bus.ldata, bus.rdata, e.l, e.r);
        end
        n_chk++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL strobe_latency cyc=%0d required %0d", cyc, e.cyc);
        end
        n_chk++;
        if (bus.locked !== e.lk) begin
          n_fail++;
          $display("FAIL locked_at_strobe got %b required %b (ldata=%h)", bus.locked, e.lk, e.l);
        end
        n_chk++;
        if (bus.ear !== e.er) begin
          n_fail++;
          $display("FAIL ear_at_strobe got %b required %b (ldata=%h)", bus.ear, e.er, e.l);
        end
        $display("strobe cyc=%0d ldata=%h rdata=%h locked=%b ear=%b", cyc, bus.ldata, bus.rdata, bus.locked, bus.ear);
      end
    end
  end

  // One half-frame of nbits sck periods (18 clocks each); lr and d change with sck falling.
  task automatic send_half(input logic lrv, input logic [15:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      bus.sck = 1'b0;
      bus.d   = (k >= 1 && k <= DW) ? w[DW-k] : 1'b0;
      if (k == 0) begin
        if (lrv == 1'b0 && bus.lr == 1'b1 && pend_valid) begin
          sb.push_back('{pend_l, pend_r, cyc + 4, pend_lk, pend_er});
          pend_valid = 1'b0;
        end
        bus.lr = lrv;
      end
      repeat (9) @(negedge clk);
      bus.sck = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nbits,
                       input logic lk, input logic er);
    send_half(1'b0, l, nbits);
    send_half(1'b1, r, nbits);
    pend_l = l; pend_r = r; pend_lk = lk; pend_er = er;
    pend_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    bus.sck = 1'b0; bus.lr = 1'b0; bus.d = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sck = 1'($urandom_range(1, 0));
      bus.lr  = 1'($urandom_range(1, 0));
      bus.d   = 1'($urandom_range(1, 0));
      outs = {bus.ldata, bus.rdata, bus.strobe, bus.locked, bus.ear};
      n_chk++;
      if (outs !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got %h required 0", i, outs);
      end
    end
    @(negedge clk);
    reset = 1'b0; bus.lr = 1'b1; bus.sck = 1'b0; bus.d = 1'b0;
    repeat (50) @(negedge clk);
    outs = {bus.ldata, bus.rdata, bus.strobe, bus.locked, bus.ear};
    n_chk++;
    if (outs !== 35'd0 || strobes_seen !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle outputs=%h strobes=%0d required 0 0", outs, strobes_seen);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    send_half(1'b1, 16'h7FFE, 20);
    frame(16'h8001, 16'h7FFE, 32, 1'b0, 1'b0);
    frame(16'h8001, 16'h7FFE, 32, 1'b1, 1'b0);
    frame(16'h8001, 16'h7FFE, 32, 1'b1, 1'b0);
    $display("test_stream done");
  endtask

  task automatic test_short_half();
    n_chk++;
    if (bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL locked_before_short got %b required 1", bus.locked);
    end
    send_half(1'b0, 16'hFFFF, 10);
    fork
      send_half(1'b1, 16'h7FFE, 32);
      begin
        repeat (4) @(negedge clk);
        n_chk++;
        if (bus.locked !== 1'b1) begin
          n_fail++;
          $display("FAIL locked_before_commit got %b required 1", bus.locked);
        end
        @(negedge clk);
        n_chk++;
        if (bus.locked !== 1'b0) begin
          n_fail++;
          $display("FAIL locked_drop_on_commit got %b required 0", bus.locked);
        end
      end
    join
    pend_l = 16'hFF80; pend_r = 16'h7FFE; pend_lk = 1'b0; pend_er = 1'b0;
    pend_valid = 1'b1;
    frame(16'h8001, 16'h7FFE, 32, 1'b0, 1'b0);
    frame(16'h8001, 16'h7FFE, 32, 1'b1, 1'b0);
    $display("test_short_half done");
  endtask

  task automatic test_overrun();
    frame(16'hA5C3, 16'h3C5A, 40, 1'b0, 1'b0);
    frame(16'hA5C3, 16'h3C5A, 40, 1'b0, 1'b0);
    n_chk++;
    if (bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL locked_after_overrun got %b required 0", bus.locked);
    end
    $display("test_overrun done");
  endtask

  task automatic test_ear();
`ifdef I2S_RX_EAR_HYST_EN
    logic [15:0] lv [4] = '{16'd600, 16'd800, 16'd400, 16'd200};
    logic        ev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
    logic [15:0] lv [3] = '{16'd600, 16'd400, 16'd600};
    logic        ev [3] = '{1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < $size(lv); i++) begin
      frame(lv[i], 16'h1234, 32, (i != 0), ev[i]);
    end
    send_half(1'b0, 16'h0000, 32);
    $display("test_ear done");
  endtask

  task automatic test_reset_mid_frame();
    send_half(1'b1, 16'h0F0F, 32);
    pend_l = 16'h0000; pend_r = 16'h0F0F; pend_lk = 1'b1; pend_er = 1'b0;
    pend_valid = 1'b1;
    fork
      send_half(1'b0, 16'h1111, 32);
      begin
        repeat (100) @(negedge clk);
        n_chk++;
        if (bus.locked !== 1'b1) begin
          n_fail++;
          $display("FAIL locked_before_reset got %b required 1", bus.locked);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pend_valid = 1'b0;
        n_chk++;
        if (bus.locked !== 1'b0) begin
          n_fail++;
          $display("FAIL locked_after_reset got %b required 0", bus.locked);
        end
      end
    join
    send_half(1'b1, 16'h2222, 32);
    frame(16'h3333, 16'h4444, 32, 1'b0, 1'b1);
    send_half(1'b0, 16'h0000, 8);
    repeat (30) @(negedge clk);
    n_chk++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL pending_strobes got %0d required 0", sb.size());
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_short_half();
    test_overrun();
    test_ear();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
